data_sram_responder: RTL and testbench
======================================

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 The block SHALL have parameter AW, default 10, giving the word-index width of the internal memory (2^AW 32-bit words).
REQ-002 The block SHALL have parameter LAT, default 2, giving the request-to-response latency in cycles; the legal range is 1..7.
REQ-003 Port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port `rst`, input, 1 bit: reset; asynchronous and active-low (0 = reset).
REQ-005 Port `req`, input, 1 bit: the CPU data side presents a request.
REQ-006 Port `wr`, input, 1 bit: 1 = write, 0 = read.
REQ-007 Port `addr`, input, 32 bits: byte address.
REQ-008 Port `wstrb`, input, 4 bits: byte-lane write enables, aligned with the CPU `sel` encoding (bit i = byte i).
REQ-009 Port `wdata`, input, 32 bits: write data, already lane-aligned.
REQ-010 Port `addr_ok`, output, 1 bit: the request is accepted this cycle.
REQ-011 Port `data_ok`, output, 1 bit: one-cycle response pulse for the oldest accepted request.
REQ-012 Port `rdata`, output, 32 bits: read data, valid while `data_ok` is high.

Function
REQ-013 Handshake: a request SHALL be accepted on a rising edge where `req` and `addr_ok` are both high; `wr`, `addr`, `wstrb` and `wdata` are captured on that edge.
REQ-014 Pending queue: the block SHALL keep an in-order queue of pending requests, depth 2, with a 2-bit count (0..2).
REQ-015 `addr_ok`: `addr_ok` SHALL equal `req` AND (count < 2), combinationally.
- It does not depend on a retirement in the same cycle.
- A full queue SHALL refuse new requests.
REQ-016 Age counter: each queue entry SHALL hold a 3-bit age counter.
- The counter loads 1 on acceptance.
- It increments each cycle and saturates at LAT.
REQ-017 Head response: the head entry SHALL respond in the cycle its age equals LAT.
- `data_ok` = 1 for exactly that cycle.
- The entry then retires (pops) at the next edge.
- First-request latency is therefore exactly LAT cycles after the accepting edge.
REQ-018 Ordering: responses SHALL be in acceptance order, and at most one `data_ok` SHALL occur per cycle.
- A second entry already aged to LAT responds in the cycle after the head's response.
- Pipelined throughput is therefore 1 response per cycle.
REQ-019 Write commit: a write SHALL commit on the edge ending its `data_ok` cycle.
- Only the bytes whose `wstrb` bit is 1 are updated.
- `rdata` SHALL be 0 for write responses.
REQ-020 Read timing: a read SHALL return the memory word at index `addr[AW+1:2]` as sampled during its `data_ok` cycle.
- A read queued behind a write to the same word therefore returns the post-write value.
REQ-021 Addressing: `addr` bits above AW+1 and bits [1:0] SHALL be ignored; alignment checking belongs to the CPU.
REQ-022 Pending-state mux: while `data_ok` = 0, `rdata` SHALL hold its last value.
REQ-023 Simultaneous events: acceptance and retirement on the same edge SHALL be allowed (count unchanged, the new entry becomes the tail).
REQ-024 State machine: the block SHALL use states IDLE (count 0), BUSY (count 1), FULL (count 2).
- Transitions: +1 on accept-only, −1 on retire-only, unchanged on both or neither.
REQ-025 Stall contract: `req` held high with `addr_ok` low SHALL NOT alter any state.
REQ-026 Memory contents: memory contents SHALL NOT be reset; they are undefined until written.

Reset
REQ-027 While `rst` = 0, the block SHALL clear queue, count and ages; `data_ok` = 0, `rdata` = 0 and `addr_ok` = 0, regardless of `req`.
REQ-028 Reset mid-operation SHALL discard pending requests, including uncommitted writes, and no `data_ok` SHALL follow.
REQ-029 Reset exit: the first request SHALL be accepted on the first rising edge after `rst` returns to 1 with `req` = 1.

Verification
REQ-030 With LAT=2: write addr 0x40, wdata 0xDEADBEEF, wstrb 0xF, accepted at edge T -> `data_ok` = 1 in cycle T+2, `rdata` = 0; then read 0x40 -> `rdata` = 0xDEADBEEF with `data_ok`.
REQ-031 Byte strobes: word 0x80 = 0x11223344, then write wdata 0xAABBCCDD wstrb 0b0101 -> a read of 0x80 returns 0x11BB33DD.
REQ-032 Back-to-back: `req` held high for 4 cycles with reads of 0x0, 0x4, 0x8, 0xC -> `addr_ok` drops when count = 2; four `data_ok` pulses occur in address order; no request is lost.
REQ-033 Read behind write: write 0x10 = 0x5A5A5A5A, then a read of 0x10 accepted the next cycle -> the read returns 0x5A5A5A5A one cycle after the write's `data_ok`.
REQ-034 Reset mid-operation: write 0x20 = 0x12345678 accepted, `rst` pulled low before `data_ok` -> `data_ok` never asserts; a later read of 0x20 does not return 0x12345678 unless written again.
REQ-035 Latency sweep: with LAT=1 and LAT=7, a single read -> `data_ok` exactly LAT cycles after acceptance.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: two-deep in-order request queue with fixed LAT-cycle
// response latency, byte-strobed write commit at retirement and combinational read.
//
// state | meaning
// IDLE  | queue empty (count 0)
// BUSY  | one pending request (count 1)
// FULL  | two pending requests (count 2), new requests refused
module data_sram_responder #(
  parameter int AW  = 10,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam logic [2:0] LAT_C = 3'(LAT);

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] idx;
    logic [3:0]    strb;
    logic [31:0]   data;
    logic [2:0]    age;
  } entry_t;

  typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;

  state_t      state, state_n;
  entry_t      head, tail, head_n, tail_n, incoming;
  logic        push, pop;
  logic [31:0] resp_data, rdata_q;
  logic [31:0] mem [0:(1<<AW)-1];
  logic        addr_unused;

  assign addr_unused = ^{addr[31:AW+2], addr[1:0]};

  function automatic entry_t aged(input entry_t e);
    entry_t r;
    r     = e;
    r.age = (e.age >= LAT_C) ? LAT_C : e.age + 3'd1;
    return r;
  endfunction

  always_comb begin
    state_n = state;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    case (state)
      IDLE: begin
        addr_ok = rst & req;
        if (addr_ok) state_n = BUSY;
      end
      BUSY: begin
        addr_ok = rst & req;
        data_ok = rst & (head.age == LAT_C);
        if (addr_ok && !data_ok)      state_n = FULL;
        else if (data_ok && !addr_ok) state_n = IDLE;
      end
      FULL: begin
        data_ok = rst & (head.age == LAT_C);
        if (data_ok) state_n = BUSY;
      end
      default: state_n = IDLE;
    endcase
  end

  assign push = addr_ok;
  assign pop  = data_ok;

  // Surviving entries shift toward the head; the new one lands in the first free slot.
  always_comb begin
    incoming.wr   = wr;
    incoming.idx  = addr[AW+1:2];
    incoming.strb = wstrb;
    incoming.data = wdata;
    incoming.age  = 3'd1;
    head_n = pop ? aged(tail) : aged(head);
    tail_n = aged(tail);
    if (push) begin
      if (state == IDLE || (state == BUSY && pop)) head_n = incoming;
      else                                         tail_n = incoming;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      head  <= head_n;
      tail  <= tail_n;
      if (pop) rdata_q <= resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (pop && head.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (head.strb[i]) mem[head.idx][8*i +: 8] <= head.data[8*i +: 8];
      end
    end
  end

  assign resp_data = head.wr ? 32'd0 : mem[head.idx];
  assign rdata     = data_ok ? resp_data : rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: LAT=1/2/7 instances on shared stimulus, each checked
// every cycle against a scheduled-response model, plus directed literal expectations.
module tb_data_sram_responder;

  localparam int LATS [3] = '{1, 2, 7};

  logic        clk = 1'b0;
  logic        rst, req, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        ok_w [3];
  logic        dv_w [3];
  logic [31:0] rd_w [3];

  always #5 clk = ~clk;

  data_sram_responder #(.AW(10), .LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(ok_w[0]), .data_ok(dv_w[0]), .rdata(rd_w[0]));
  data_sram_responder #(.AW(10), .LAT(2)) u_l2 (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(ok_w[1]), .data_ok(dv_w[1]), .rdata(rd_w[1]));
  data_sram_responder #(.AW(10), .LAT(7)) u_l7 (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(ok_w[2]), .data_ok(dv_w[2]), .rdata(rd_w[2]));

  int n_tests = 0;
  int n_fail  = 0;
  int e       = 0;

  // Model: each pending request carries the edge at which its response is due.
  int        p_n    [3];
  bit        p_wr   [3][2];
  int        p_idx  [3][2];
  bit [3:0]  p_strb [3][2];
  bit [31:0] p_data [3][2];
  int        p_resp [3][2];
  bit [31:0] mm [3][1024];
  bit [3:0]  kn [3][1024];
  bit [31:0] last_v [3];
  bit [31:0] last_m [3];
  int        dut_acc [3];
  int        dut_rsp [3];
  bit [31:0] log_v [$];
  int        log_e [$];
  bit        b2b = 1'b0;
  bit        saw_stall = 1'b0;

  bit        eok, edv;
  bit [31:0] erd, em;
  int        h, ix;

  function automatic bit [31:0] bmask(input bit [3:0] k);
    bit [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp,
                         input logic [31:0] m);
    n_tests++;
    if ((got & m) !== (exp & m)) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (mask %h) at edge %0d", name, got, exp, m, e);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired at edge %0d", name, e);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      p_n[k] = 0; last_v[k] = '0; last_m[k] = '1; dut_acc[k] = -1; dut_rsp[k] = -1;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst) p_n[k] = 0;
        eok = rst && req && (p_n[k] < 2);
        edv = rst && (p_n[k] > 0) && (p_resp[k][0] == e);
        if (!rst) begin
          erd = '0; em = '1;
        end else if (edv) begin
          if (p_wr[k][0]) begin
            erd = '0; em = '1;
          end else begin
            erd = mm[k][p_idx[k][0]]; em = bmask(kn[k][p_idx[k][0]]);
          end
        end else begin
          erd = last_v[k]; em = last_m[k];
        end
        check32($sformatf("addr_ok_L%0d", LATS[k]), {31'b0, ok_w[k]}, {31'b0, eok}, 32'h1);
        check32($sformatf("data_ok_L%0d", LATS[k]), {31'b0, dv_w[k]}, {31'b0, edv}, 32'h1);
        check32($sformatf("rdata_L%0d", LATS[k]), rd_w[k], erd, em);
        if (rst && ok_w[k]) dut_acc[k] = e;
        if (dv_w[k]) dut_rsp[k] = e;
        if (k == 1 && b2b && req && rst && !ok_w[1]) saw_stall = 1'b1;
        if (rst) begin
          if (edv) begin
            if (p_wr[k][0]) begin
              ix = p_idx[k][0];
              for (int i = 0; i < 4; i++) begin
                if (p_strb[k][0][i]) begin
                  mm[k][ix][8*i +: 8] = p_data[k][0][8*i +: 8];
                  kn[k][ix][i] = 1'b1;
                end
              end
            end
            last_v[k] = erd; last_m[k] = em;
            if (k == 1) begin log_v.push_back(rd_w[1]); log_e.push_back(e); end
            p_wr[k][0] = p_wr[k][1]; p_idx[k][0] = p_idx[k][1]; p_strb[k][0] = p_strb[k][1];
            p_data[k][0] = p_data[k][1]; p_resp[k][0] = p_resp[k][1];
            p_n[k]--;
          end
          if (eok) begin
            h = p_n[k];
            p_wr[k][h] = wr; p_idx[k][h] = int'((addr >> 2) & 32'd1023);
            p_strb[k][h] = wstrb; p_data[k][h] = wdata;
            p_resp[k][h] = e + LATS[k];
            if (h > 0 && p_resp[k][h-1] + 1 > p_resp[k][h]) p_resp[k][h] = p_resp[k][h-1] + 1;
            p_n[k]++;
          end
        end else begin
          last_v[k] = '0; last_m[k] = '1;
        end
      end
      e++;
    end
  end

  task automatic issue(input bit w, input bit [31:0] a, input bit [3:0] s, input bit [31:0] d,
                       output int waited);
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d; waited = 0;
    while (1) begin
      @(negedge clk);
      if (ok_w[1]) break;
      waited++;
      if (waited > 50) begin fail_now("issue_timeout"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int c = 0;
    req = 1'b0;
    while ((p_n[0] + p_n[1] + p_n[2]) != 0 && c < 200) begin @(posedge clk); #1; c++; end
    if (c >= 200) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  bit [31:0] exp_log [18] = '{32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 32'h11BB33DD,
                              32'h0, 32'h0, 32'h0, 32'h0,
                              32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003,
                              32'h0, 32'h5A5A5A5A, 32'h0, 32'hCAFEF00D};

  initial begin
    int w;
    rst = 1'b0; req = 1'b1; wr = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check32($sformatf("reset_addr_ok_L%0d", LATS[k]), {31'b0, ok_w[k]}, 32'h0, 32'h1);
      check32($sformatf("reset_data_ok_L%0d", LATS[k]), {31'b0, dv_w[k]}, 32'h0, 32'h1);
      check32($sformatf("reset_rdata_L%0d", LATS[k]), rd_w[k], 32'h0, '1);
    end
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    issue(1'b1, 32'h40, 4'hF, 32'hDEADBEEF, w); drain();
    check32("write_latency_L2", 32'(dut_rsp[1] - dut_acc[1]), 32'd2, '1);
    issue(1'b0, 32'h40, 4'h0, 32'h0, w); drain();
    issue(1'b0, 32'h40, 4'h0, 32'h0, w); drain();
    for (int k = 0; k < 3; k++)
      check32($sformatf("read_latency_L%0d", LATS[k]), 32'(dut_rsp[k] - dut_acc[k]),
              32'(LATS[k]), '1);

    issue(1'b1, 32'h80, 4'hF, 32'h11223344, w); drain();
    issue(1'b1, 32'h80, 4'b0101, 32'hAABBCCDD, w); drain();
    issue(1'b0, 32'h80, 4'h0, 32'h0, w); drain();
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'(i * 4), 4'hF, 32'hA0000000 + 32'(i), w); drain();
    end
    b2b = 1'b1;
    for (int i = 0; i < 4; i++) issue(1'b0, 32'(i * 4), 4'h0, 32'h0, w);
    b2b = 1'b0;
    drain();
    check32("b2b_addr_ok_dropped", {31'b0, saw_stall}, 32'h1, 32'h1);

    issue(1'b1, 32'h10, 4'hF, 32'h5A5A5A5A, w);
    issue(1'b0, 32'h10, 4'h0, 32'h0, w);
    drain();
    check32("read_behind_write_gap", 32'(log_e[log_e.size()-1] - log_e[log_e.size()-2]),
            32'd1, '1);

    issue(1'b1, 32'h20, 4'hF, 32'hCAFEF00D, w); drain();
    issue(1'b1, 32'h20, 4'hF, 32'h12345678, w);
    rst = 1'b0; req = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    issue(1'b0, 32'h20, 4'h0, 32'h0, w);
    check32("reset_exit_accept_wait", 32'(w), 32'd0, '1);
    drain();

    check32("log_count", 32'(log_v.size()), 32'd18, '1);
    for (int i = 0; i < 18 && i < log_v.size(); i++)
      check32($sformatf("log_%0d", i), log_v[i], exp_log[i], '1);

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) != 0);
      req   = ($urandom_range(0, 9) < 7);
      wr    = $urandom_range(0, 1);
      addr  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) |
              32'($urandom_range(0, 3));
      wstrb = 4'($urandom);
      wdata = $urandom;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d tests, expected completion", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
